// File: rtl/pid_controller_mc_pkg.sv
// Shared types and helpers for the multi-channel PID controller.
// Optional feature macro used by this block: PID_DERIV_ON_MEAS_EN.
package pid_pkg;

    localparam int PID_DW    = 8;
    localparam int PID_GW    = 8;
    localparam int PID_FRAC  = 4;
    localparam int PID_ACC_W = 24;
    localparam int PID_NCH   = 4;

    typedef enum logic [2:0] {
        IDLE,
        MUL_P,
        MUL_I,
        MUL_D,
        SUM,
        OUT
    } state_e;

    function automatic logic signed [63:0] sat_acc(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/pid_controller_mc_if.sv
// Sample-in / result-out valid-ready bundle for pid_controller_mc.
// The controller side uses the slave modport.
interface pid_controller_mc_if
    import pid_pkg::*;
#(
    parameter int DW = PID_DW,
    parameter int GW = PID_GW,
    parameter int CW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ch;
    logic          in_clear;
    logic [DW-1:0] setpoint;
    logic [DW-1:0] feedback;
    logic [GW-1:0] kp;
    logic [GW-1:0] ki;
    logic [GW-1:0] kd;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ch;
    logic [DW-1:0] control_signal;
    logic          sat_hi;
    logic          sat_lo;

    modport master (
        output in_valid, in_ch, in_clear,
        output setpoint, feedback,
        output kp, ki, kd, out_ready,
        input  in_ready, out_valid, out_ch,
        input  control_signal, sat_hi, sat_lo
    );

    modport slave (
        input  in_valid, in_ch, in_clear,
        input  setpoint, feedback,
        input  kp, ki, kd, out_ready,
        output in_ready, out_valid, out_ch,
        output control_signal, sat_hi, sat_lo
    );
endinterface

// File: rtl/pid_controller_mc_sat.sv
// Signed-to-unsigned clamp: x limited to [0, 2^DW-1] with
// high/low saturation flags.
module pid_sat #(
    parameter int IW = 26,
    parameter int DW = 8
) (
    input  logic signed [IW-1:0] x,
    output logic        [DW-1:0] value,
    output logic                 hi,
    output logic                 lo
);
    assign lo    = x[IW-1];
    assign hi    = !x[IW-1] && (|x[IW-2:DW]);
    assign value = hi ? '1 : (lo ? '0 : x[DW-1:0]);
endmodule

// File: rtl/pid_controller_mc.sv
// Time-multiplexed NCH-channel PID loop sharing one signed multiplier.
// Define PID_DERIV_ON_MEAS_EN for derivative-on-measurement.
module pid_controller_mc
    import pid_pkg::*;
#(
    parameter int DW    = PID_DW,
    parameter int GW    = PID_GW,
    parameter int FRAC  = PID_FRAC,
    parameter int ACC_W = PID_ACC_W,
    parameter int NCH   = PID_NCH,
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input logic               clk,
    input logic               rst_n,
    pid_controller_mc_if.slave bus
);
    localparam int PW = DW + GW + 3;
    localparam int SW = ACC_W + 2;

    state_e state_q, state_d;

    logic [CW-1:0]          ch_q;
    logic                   clr_q;
    logic [GW-1:0]          kp_q, ki_q, kd_q;
    logic signed [DW:0]     err_q;
    logic signed [PW-1:0]   p_q, d_q;
    logic signed [ACC_W-1:0] icand_q;
    logic signed [ACC_W-1:0] integ_q [NCH];
    logic signed [DW:0]     prev_q  [NCH];
    logic [DW-1:0]          ctl_q;
    logic [CW-1:0]          och_q;
    logic                   hi_q, lo_q;
`ifdef PID_DERIV_ON_MEAS_EN
    logic [DW-1:0]          fb_q;
`endif

    logic                    ch_ok;
    logic signed [ACC_W-1:0] integ_cur;
    logic signed [DW:0]      prev_cur;
    logic signed [DW+1:0]    diff;
    logic signed [GW:0]      mul_a;
    logic signed [DW+1:0]    mul_b;
    logic signed [PW-1:0]    prod;
    logic signed [63:0]      isum;
    logic signed [SW-1:0]    total;
    logic [DW-1:0]           sat_val;
    logic                    sat_hi_w, sat_lo_w;
    logic                    err_pos, err_neg, commit;

    assign ch_ok     = 32'(bus.in_ch) < NCH;
    assign integ_cur = clr_q ? '0 : integ_q[ch_q];
    assign prev_cur  = clr_q ? '0 : prev_q[ch_q];

`ifdef PID_DERIV_ON_MEAS_EN
    assign diff = (DW+2)'(prev_cur)
                - (DW+2)'($signed({1'b0, fb_q}));
`else
    assign diff = (DW+2)'(err_q) - (DW+2)'(prev_cur);
`endif

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            MUL_P: begin
                mul_a = {1'b0, kp_q};
                mul_b = (DW+2)'(err_q);
            end
            MUL_I: begin
                mul_a = {1'b0, ki_q};
                mul_b = (DW+2)'(err_q);
            end
            MUL_D: begin
                mul_a = {1'b0, kd_q};
                mul_b = diff;
            end
            default: ;
        endcase
    end

    assign prod  = PW'(mul_a) * PW'(mul_b);
    assign isum  = 64'(integ_cur) + 64'(prod);
    assign total = (SW'(p_q) + SW'(icand_q) + SW'(d_q)) >>> FRAC;

    pid_sat #(
        .IW (SW),
        .DW (DW)
    ) u_sat (
        .x     (total),
        .value (sat_val),
        .hi    (sat_hi_w),
        .lo    (sat_lo_w)
    );

    assign err_pos = !err_q[DW] && (|err_q);
    assign err_neg = err_q[DW];
    // Conditional integration: freeze the integrator while pushing further into saturation.
    assign commit  = !((sat_hi_w && err_pos) || (sat_lo_w && err_neg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.in_valid && ch_ok) state_d = MUL_P;
            MUL_P: state_d = MUL_I;
            MUL_I: state_d = MUL_D;
            MUL_D: state_d = SUM;
            SUM:   state_d = OUT;
            OUT:   if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q    <= '0;
            clr_q   <= 1'b0;
            kp_q    <= '0;
            ki_q    <= '0;
            kd_q    <= '0;
            err_q   <= '0;
            p_q     <= '0;
            d_q     <= '0;
            icand_q <= '0;
            ctl_q   <= '0;
            och_q   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
`ifdef PID_DERIV_ON_MEAS_EN
            fb_q    <= '0;
`endif
            for (int i = 0; i < NCH; i++) begin
                integ_q[i] <= '0;
                prev_q[i]  <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: if (bus.in_valid) begin
                    ch_q  <= bus.in_ch;
                    clr_q <= bus.in_clear;
                    kp_q  <= bus.kp;
                    ki_q  <= bus.ki;
                    kd_q  <= bus.kd;
                    err_q <= $signed({1'b0, bus.setpoint})
                           - $signed({1'b0, bus.feedback});
`ifdef PID_DERIV_ON_MEAS_EN
                    fb_q  <= bus.feedback;
`endif
                end
                MUL_P: p_q <= prod;
                MUL_I: icand_q <= ACC_W'(sat_acc(isum, ACC_W));
                MUL_D: d_q <= prod;
                SUM: begin
                    ctl_q <= sat_val;
                    hi_q  <= sat_hi_w;
                    lo_q  <= sat_lo_w;
                    och_q <= ch_q;
                    if (commit)     integ_q[ch_q] <= icand_q;
                    else if (clr_q) integ_q[ch_q] <= '0;
`ifdef PID_DERIV_ON_MEAS_EN
                    prev_q[ch_q] <= $signed({1'b0, fb_q});
`else
                    prev_q[ch_q] <= err_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready       = (state_q == IDLE);
    assign bus.out_valid      = (state_q == OUT);
    assign bus.out_ch         = och_q;
    assign bus.control_signal = ctl_q;
    assign bus.sat_hi         = hi_q;
    assign bus.sat_lo         = lo_q;
endmodule

// File: tb/tb_pid_controller_mc.sv
// Scoreboard bench for pid_controller_mc: directed samples with
// hand-computed results, checked by an independent output monitor.
module tb_pid_controller_mc;
    import pid_pkg::*;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] val;
        logic       hi;
        logic       lo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    pid_controller_mc_if #(.DW(8), .GW(8), .CW(2)) bus ();

    pid_controller_mc #(
        .DW    (8),
        .GW    (8),
        .FRAC  (4),
        .ACC_W (24),
        .NCH   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Output monitor: a result is consumed on the next posedge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: ch=%0d val=%0d, none expected",
                         bus.out_ch, bus.control_signal);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.out_ch !== e.ch || bus.control_signal !== e.val ||
                    bus.sat_hi !== e.hi || bus.sat_lo !== e.lo) begin
                    errors++;
                    $display("FAIL result: got ch=%0d val=%0d hi=%0d lo=%0d, expected ch=%0d val=%0d hi=%0d lo=%0d",
                             bus.out_ch, bus.control_signal, bus.sat_hi,
                             bus.sat_lo, e.ch, e.val, e.hi, e.lo);
                end
            end
        end
    end

    task automatic send(
        input logic [1:0] ch,
        input logic       clr,
        input logic [7:0] sp,
        input logic [7:0] fb,
        input logic [7:0] kp,
        input logic [7:0] ki,
        input logic [7:0] kd,
        input logic [7:0] ev,
        input logic       eh,
        input logic       el,
        input bit         expect_out
    );
        int n;
        exp_t e;
        @(negedge clk);
        bus.in_ch    = ch;
        bus.in_clear = clr;
        bus.setpoint = sp;
        bus.feedback = fb;
        bus.kp       = kp;
        bus.ki       = ki;
        bus.kd       = kd;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0, expected 1");
            bus.in_valid = 1'b0;
            return;
        end
        if (expect_out) begin
            e.ch  = ch;
            e.val = ev;
            e.hi  = eh;
            e.lo  = el;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_clear = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        int n;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_ch     = '0;
        bus.in_clear  = 1'b0;
        bus.setpoint  = '0;
        bus.feedback  = '0;
        bus.kp        = '0;
        bus.ki        = '0;
        bus.kd        = '0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_control", int'(bus.control_signal), 0);
        check("rst_out_ch", int'(bus.out_ch), 0);
        check("rst_sat_hi", int'(bus.sat_hi), 0);
        check("rst_sat_lo", int'(bus.sat_lo), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // ch0 integral builds 20 -> 40 -> 60
        send(0, 0, 100, 90, 16, 2, 1, 11, 0, 0, 1);
        send(0, 0, 100, 90, 16, 2, 1, 12, 0, 0, 1);
        send(0, 0, 100, 90, 16, 2, 1, 13, 0, 0, 1);
        send(1, 0, 100, 90, 16, 2, 1, 11, 0, 0, 1);
        // -950 >>> 4 = -60: clamps low, integral frozen
        send(2, 0,   0, 50, 16, 2, 1,  0, 0, 1, 1);
        send(2, 0,  50, 50, 16, 2, 0,  0, 0, 0, 1);
        // 65790 >>> 4 clamps high; a committed 510 would give 31 next
        send(3, 0, 255,  0, 255, 2, 1, 255, 1, 0, 1);
        send(3, 0,   0,  0, 16, 2, 0,  0, 0, 0, 1);
        drain();

        // Back-pressure: ch1 integral 20, prev 10 -> 200 >>> 4 = 12
        bus.out_ready = 1'b0;
        send(1, 0, 100, 90, 16, 2, 1, 12, 0, 0, 1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_out_valid", int'(bus.out_valid), 1);
            check("hold_control", int'(bus.control_signal), 12);
            check("hold_out_ch", int'(bus.out_ch), 1);
            check("hold_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();
        @(negedge clk);
        check("post_hold_in_ready", int'(bus.in_ready), 1);

        // in_clear makes ch0 fresh again, then it resumes from 20/10
        send(0, 1, 100, 90, 16, 2, 1, 11, 0, 0, 1);
        send(0, 0, 100, 90, 16, 2, 1, 12, 0, 0, 1);
        drain();

        // Reset while the sample sits in MUL_I
        send(0, 0, 100, 90, 16, 2, 1, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        send(0, 0, 100, 90, 16, 2, 1, 11, 0, 0, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
